// File: rtl/fpu_sched_pkg.sv
// Shared scheduling types for FPU-internal arbiters.
// Contents:
//   FMUL_LAT_MAX - deepest supported pipeline around the shared multiplier
//   N_REQ_MAX    - largest supported requester count
//   id_width()   - requester-id width for a given requester count (minimum 1)
//   stage_t      - one pipeline slot: {valid, id, data}; data holds {x1, x2} in the
//                  first stage and the product in [31:0] in every later stage
package fpu_sched_pkg;

   localparam int unsigned FMUL_LAT_MAX = 4;
   localparam int unsigned N_REQ_MAX    = 4;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Sized for the largest requester count; narrower configs use the low bits.
   localparam int unsigned ID_W_MAX = id_width(N_REQ_MAX);

   typedef struct packed {
      logic                valid;
      logic [ID_W_MAX-1:0] id;
      logic [63:0]         data;
   } stage_t;

endpackage

// File: rtl/fmul.sv
// Combinational IEEE-754 single-precision multiplier, round-to-nearest-even.
// Normalized operands only: zero/denormal exponents are treated as zero, results
// that underflow flush to signed zero, overflow saturates to infinity.
// Ports:
//   x1, x2 - operands
//   y      - product
module fmul (
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   output logic [31:0] y
);

   logic               sgn;
   logic [7:0]         e1, e2;
   logic [23:0]        m1, m2;
   logic [47:0]        prod;
   logic [23:0]        mant;
   logic               guard, sticky, rnd;
   logic [24:0]        mant_r;
   logic [22:0]        frac;
   logic signed [10:0] exp_s;
   logic               nan1, nan2;

   always_comb begin
      sgn  = x1[31] ^ x2[31];
      e1   = x1[30:23];
      e2   = x2[30:23];
      m1   = {1'b1, x1[22:0]};
      m2   = {1'b1, x2[22:0]};
      prod = m1 * m2;

      // Product of two [1,2) mantissas lies in [1,4); pick the leading one.
      if (prod[47]) begin
         mant   = prod[47:24];
         guard  = prod[23];
         sticky = |prod[22:0];
      end else begin
         mant   = prod[46:23];
         guard  = prod[22];
         sticky = |prod[21:0];
      end

      rnd    = guard & (sticky | mant[0]);
      mant_r = {1'b0, mant} + {24'd0, rnd};
      // Rounding carry-out leaves 1.000..0, so the fraction is simply shifted.
      frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
      exp_s  = $signed({3'b000, e1}) + $signed({3'b000, e2}) - 11'sd127
             + $signed({10'd0, prod[47]}) + $signed({10'd0, mant_r[24]});

      y = {sgn, exp_s[7:0], frac};
      if (e1 == 8'd0 || e2 == 8'd0) begin
         y = {sgn, 31'd0};
      end else if (exp_s >= 11'sd255) begin
         y = {sgn, 8'hFF, 23'd0};
      end else if (exp_s <= 11'sd0) begin
         y = {sgn, 31'd0};
      end

      nan1 = (e1 == 8'hFF) && (x1[22:0] != 23'd0);
      nan2 = (e2 == 8'hFF) && (x2[22:0] != 23'd0);
      if (e1 == 8'hFF || e2 == 8'hFF) begin
         if (nan1 || nan2 || e1 == 8'd0 || e2 == 8'd0) begin
            y = 32'h7FC00000;
         end else begin
            y = {sgn, 8'hFF, 23'd0};
         end
      end
   end

endmodule

// File: rtl/fmul_arbiter_rr.sv
// Round-robin arbiter with an internal rotating priority pointer.
// Ports:
//   clk, rstn - clock, asynchronous active-low reset (pointer -> 0)
//   req       - request vector
//   en        - grant allowed this cycle; a grant is always an accept
//   gnt       - one-hot grant, first request at or after the pointer
module rr_arbiter
   import fpu_sched_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] gnt
);

   localparam int unsigned IW = id_width(N);

   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] win, idx;
   logic          found;

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int unsigned off = 0; off < N; off++) begin
         idx = IW'((32'(ptr_q) + off) % N);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end

      gnt   = '0;
      ptr_d = ptr_q;
      if (en && found) begin
         gnt[win] = 1'b1;
         ptr_d    = (32'(win) == N - 1) ? '0 : win + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/fmul_arbiter.sv
// Shares one combinational fmul between N_REQ requesters through a LAT-deep
// registered pipeline. Round-robin issue, in-order return, per-requester
// backpressure; empty slots behind a stalled head keep filling.
// Ports:
//   clk, rstn  - clock, asynchronous active-low reset
//   req_valid  - per-requester operation valid
//   req_x1/x2  - operands, requester i in bits [32i+31:32i]
//   req_ready  - one-hot grant (accept = req_valid & req_ready)
//   resp_valid - head result belongs to requester i (at most one bit)
//   resp_y     - product at the head
//   resp_ready - per-requester result acceptance
//   busy       - any pipeline stage occupied
module fmul_arbiter
   import fpu_sched_pkg::*;
#(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned LAT   = 2
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [32*N_REQ-1:0]  req_x1,
   input  logic [32*N_REQ-1:0]  req_x2,
   output logic [N_REQ-1:0]     req_ready,
   output logic [N_REQ-1:0]     resp_valid,
   output logic [31:0]          resp_y,
   input  logic [N_REQ-1:0]     resp_ready,
   output logic                 busy
);

   localparam int unsigned ID_W = id_width(N_REQ);

   if (LAT < 1 || LAT > FMUL_LAT_MAX) begin : g_bad_lat
      $error("fmul_arbiter: LAT out of range");
   end
   if (N_REQ < 2 || N_REQ > N_REQ_MAX) begin : g_bad_nreq
      $error("fmul_arbiter: N_REQ out of range");
   end

   stage_t            s_q [LAT];
   stage_t            s_d [LAT];
   stage_t            head;
   logic [LAT-1:0]    adv;
   logic              head_ok;
   logic [ID_W-1:0]   head_id;
   logic [ID_W-1:0]   gnt_id;
   logic [31:0]       x1_sel, x2_sel;
   logic [31:0]       fmul_y;

   assign head    = s_q[LAT-1];
   assign head_id = head.id[ID_W-1:0];

   // A stage may advance if any slot between it and the output is empty, or the
   // head drains this cycle. Written without self-reference to stay acyclic.
   always_comb begin
      head_ok = !head.valid || resp_ready[head_id];
      for (int unsigned k = 0; k < LAT; k++) begin
         adv[k] = head_ok;
         for (int unsigned j = k + 1; j < LAT; j++) begin
            if (!s_q[j].valid) adv[k] = 1'b1;
         end
      end
   end

   // Gating with rstn keeps req_ready low while reset is held.
   rr_arbiter #(
      .N (N_REQ)
   ) u_rr (
      .clk  (clk),
      .rstn (rstn),
      .req  (req_valid),
      .en   (adv[0] & rstn),
      .gnt  (req_ready)
   );

   always_comb begin
      gnt_id = '0;
      x1_sel = '0;
      x2_sel = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (req_ready[i]) begin
            gnt_id = ID_W'(i);
            x1_sel = req_x1[32*i +: 32];
            x2_sel = req_x2[32*i +: 32];
         end
      end
   end

   fmul u_fmul (
      .x1 (s_q[0].data[63:32]),
      .x2 (s_q[0].data[31:0]),
      .y  (fmul_y)
   );

   always_comb begin
      for (int unsigned k = 0; k < LAT; k++) s_d[k] = s_q[k];

      if (adv[0]) begin
         s_d[0].valid = |req_ready;
         s_d[0].id    = ID_W_MAX'(gnt_id);
         s_d[0].data  = {x1_sel, x2_sel};
      end

      for (int unsigned k = 1; k < LAT; k++) begin
         if (adv[k-1]) begin
            s_d[k] = s_q[k-1];
            if (k == 1) s_d[k].data = {32'd0, fmul_y};
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned k = 0; k < LAT; k++) s_q[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < LAT; k++) s_q[k] <= s_d[k];
      end
   end

   always_comb begin
      resp_valid = '0;
      if (head.valid) resp_valid[head_id] = 1'b1;
   end

   if (LAT == 1) begin : g_lat1
      assign resp_y = fmul_y;
   end else begin : g_latn
      assign resp_y = head.data[31:0];
   end

   always_comb begin
      busy = 1'b0;
      for (int unsigned k = 0; k < LAT; k++) busy = busy | s_q[k].valid;
   end

   // Upper data bits of the head and spare id bits are never read out.
   logic unused_head;
   assign unused_head = ^{head.data[63:32], head.id};

endmodule

// File: tb/tb_fmul_arbiter.sv
module tb_fmul_arbiter;

   localparam int unsigned N_REQ = 2;
   localparam int unsigned LAT   = 2;

   localparam logic [31:0] BP_A [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
   localparam logic [31:0] BP_Y [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
   localparam int          MS_ID [3] = '{1, 0, 0};
   localparam logic [31:0] MS_Y  [3] = '{32'h41100000, 32'h40A00000, 32'h40C00000};

   logic        clk = 1'b0;
   logic        rstn;
   logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
   logic [63:0] req_x1, req_x2;
   logic [31:0] resp_y;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   fmul_arbiter #(
      .N_REQ (N_REQ),
      .LAT   (LAT)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req_valid  (req_valid),
      .req_x1     (req_x1),
      .req_x2     (req_x2),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_y     (resp_y),
      .resp_ready (resp_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      req_x1[32*i +: 32] = a;
      req_x2[32*i +: 32] = b;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rstn       = 1'b0;
      req_valid  = '0;
      resp_ready = '0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   // Product via real arithmetic (exact in double), truncated to single.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      real         ra, rb;
      logic [63:0] d;
      logic [10:0] ea, eb, ep;
      ea = {3'b000, a[30:23]} + 11'd896;
      eb = {3'b000, b[30:23]} + 11'd896;
      ra = $bitstoreal({a[31], ea, a[22:0], 29'd0});
      rb = $bitstoreal({b[31], eb, b[22:0], 29'd0});
      d  = $realtobits(ra * rb);
      ep = d[62:52] - 11'd896;
      return {d[63], ep[7:0], d[51:29]};
   endfunction

   task automatic test_reset();
      rstn       = 1'b0;
      req_valid  = 2'b11;
      resp_ready = 2'b11;
      req_x1     = '0;
      req_x2     = '0;
      #3;
      n_checks++;
      if ({req_ready, resp_valid, busy} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy=%b rv=%b busy=%b want 00 00 0",
                  req_ready, resp_valid, busy);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({req_ready, resp_valid, busy} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_held: got rdy=%b rv=%b busy=%b want 00 00 0",
                  req_ready, resp_valid, busy);
      end
      @(posedge clk);
      #1;
      rstn      = 1'b1;
      req_valid = '0;
   endtask

   task automatic test_single();
      resp_ready = 2'b11;
      req_valid  = 2'b01;
      set_op(0, 32'h3FC00000, 32'h40000000);
      @(negedge clk);
      n_checks++;
      if ({req_ready, busy} !== 3'b010) begin
         n_fail++;
         $display("FAIL single_c0: got rdy=%b busy=%b want 01 0", req_ready, busy);
      end
      next_cycle();
      req_valid = 2'b00;
      @(negedge clk);
      n_checks++;
      if ({resp_valid, busy} !== 3'b001) begin
         n_fail++;
         $display("FAIL single_c1: got rv=%b busy=%b want 00 1", resp_valid, busy);
      end
      next_cycle();
      @(negedge clk);
      n_checks++;
      if ({resp_valid, resp_y, busy} !== {2'b01, 32'h40400000, 1'b1}) begin
         n_fail++;
         $display("FAIL single_c2: got rv=%b y=%h busy=%b want 01 40400000 1",
                  resp_valid, resp_y, busy);
      end
      next_cycle();
      @(negedge clk);
      n_checks++;
      if ({resp_valid, busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL single_c3: got rv=%b busy=%b want 00 0", resp_valid, busy);
      end
      next_cycle();
   endtask

   task automatic test_fairness();
      int nresp = 0;
      apply_reset();
      resp_ready = 2'b11;
      set_op(0, 32'h3F800000, 32'h3F800000);
      set_op(1, 32'h40400000, 32'hBF000000);
      for (int c = 0; c < 12; c++) begin
         req_valid = (c < 8) ? 2'b11 : 2'b00;
         @(negedge clk);
         if (c < 8) begin
            n_checks++;
            if (req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
               n_fail++;
               $display("FAIL fair_grant c%0d: got %b want %b", c, req_ready,
                        (c % 2 == 0) ? 2'b01 : 2'b10);
            end
         end
         if (|resp_valid) begin
            n_checks++;
            if ({resp_valid, resp_y} !== ((nresp % 2 == 0) ? {2'b01, 32'h3F800000}
                                                            : {2'b10, 32'hBFC00000})) begin
               n_fail++;
               $display("FAIL fair_resp #%0d: got rv=%b y=%h", nresp, resp_valid, resp_y);
            end
            nresp++;
         end
         next_cycle();
      end
      n_checks++;
      if (nresp != 8) begin
         n_fail++;
         $display("FAIL fair_count: got %0d results want 8", nresp);
      end
   endtask

   task automatic test_backpressure();
      int acc = 0, nresp = 0, first = -1, last = -1;
      apply_reset();
      for (int c = 0; c < 12; c++) begin
         resp_ready = (c < 5) ? 2'b10 : 2'b11;
         req_valid  = {1'b0, acc < 4};
         set_op(0, BP_A[(acc < 4) ? acc : 0], 32'h40000000);
         @(negedge clk);
         if (c >= 2 && c <= 4) begin
            n_checks++;
            if ({req_ready, resp_valid, resp_y} !== {2'b00, 2'b01, 32'h40000000}) begin
               n_fail++;
               $display("FAIL bp_hold c%0d: got rdy=%b rv=%b y=%h want 00 01 40000000",
                        c, req_ready, resp_valid, resp_y);
            end
         end
         if (c == 4) begin
            n_checks++;
            if (acc != LAT) begin
               n_fail++;
               $display("FAIL bp_accepts: got %0d want %0d", acc, LAT);
            end
         end
         if (|(resp_valid & resp_ready)) begin
            n_checks++;
            if (nresp >= 4 || resp_y !== BP_Y[(nresp < 4) ? nresp : 0]) begin
               n_fail++;
               $display("FAIL bp_order #%0d: got %h", nresp, resp_y);
            end
            if (first < 0) first = c;
            last = c;
            nresp++;
         end
         if (|(req_valid & req_ready)) acc++;
         next_cycle();
      end
      n_checks++;
      if (nresp != 4 || last - first != 3 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drain: got n=%0d span=%0d busy=%b want 4 3 0",
                  nresp, last - first, busy);
      end
   endtask

   task automatic test_mixed_stall();
      int n0 = 0, n1 = 0, nresp = 0;
      apply_reset();
      set_op(1, 32'h40400000, 32'h40400000);
      for (int c = 0; c < 10; c++) begin
         resp_ready = (c < 5) ? 2'b01 : 2'b11;
         req_valid  = {n1 == 0, (c >= 1) && (n0 < 2)};
         set_op(0, (n0 == 0) ? 32'h40A00000 : 32'h40C00000, 32'h3F800000);
         @(negedge clk);
         if (c >= 2 && c <= 4) begin
            n_checks++;
            if ({req_ready, resp_valid, resp_y} !== {2'b00, 2'b10, 32'h41100000}) begin
               n_fail++;
               $display("FAIL ms_hold c%0d: got rdy=%b rv=%b y=%h want 00 10 41100000",
                        c, req_ready, resp_valid, resp_y);
            end
         end
         if (|(resp_valid & resp_ready)) begin
            n_checks++;
            if (nresp >= 3 ||
                {resp_valid, resp_y} !== {2'(1 << MS_ID[(nresp < 3) ? nresp : 0]),
                                          MS_Y[(nresp < 3) ? nresp : 0]}) begin
               n_fail++;
               $display("FAIL ms_order #%0d: got rv=%b y=%h", nresp, resp_valid, resp_y);
            end
            nresp++;
         end
         if (req_valid[0] && req_ready[0]) n0++;
         if (req_valid[1] && req_ready[1]) n1++;
         next_cycle();
      end
      n_checks++;
      if (nresp != 3) begin
         n_fail++;
         $display("FAIL ms_count: got %0d want 3", nresp);
      end
   endtask

   task automatic test_reset_midflight();
      int nresp = 0;
      apply_reset();
      resp_ready = 2'b00;
      set_op(0, 32'h40000000, 32'h40000000);
      set_op(1, 32'h40400000, 32'h40400000);
      req_valid = 2'b11;
      next_cycle();
      next_cycle();
      req_valid = 2'b00;
      @(negedge clk);
      n_checks++;
      if ({resp_valid, busy} !== 3'b011) begin
         n_fail++;
         $display("FAIL mid_inflight: got rv=%b busy=%b want 01 1", resp_valid, busy);
      end
      #2;
      rstn = 1'b0;
      #1;
      n_checks++;
      if ({req_ready, resp_valid, busy} !== 5'b0) begin
         n_fail++;
         $display("FAIL mid_async: got rdy=%b rv=%b busy=%b want 00 00 0",
                  req_ready, resp_valid, busy);
      end
      next_cycle();
      rstn       = 1'b1;
      resp_ready = 2'b11;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if ({resp_valid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_stale c%0d: got rv=%b busy=%b want 00 0", c, resp_valid, busy);
         end
         next_cycle();
      end
      req_valid = 2'b11;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL mid_ptr: got %b want 01", req_ready);
      end
      next_cycle();
      req_valid = 2'b00;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (|(resp_valid & resp_ready)) begin
            n_checks++;
            if ({resp_valid, resp_y} !== {2'b01, 32'h40800000}) begin
               n_fail++;
               $display("FAIL mid_result: got rv=%b y=%h want 01 40800000", resp_valid, resp_y);
            end
            nresp++;
         end
         next_cycle();
      end
      n_checks++;
      if (nresp != 1) begin
         n_fail++;
         $display("FAIL mid_count: got %0d want 1", nresp);
      end
   endtask

   task automatic test_soak();
      int          q_id[$];
      logic [31:0] q_a[$], q_b[$];
      logic [31:0] held_y, a0, b0, a1, b1, e;
      logic [1:0]  held_v;
      logic        held = 1'b0;
      int          id, d;
      for (int c = 0; c < 440; c++) begin
         req_valid  = (c < 400) ? 2'($urandom) : 2'b00;
         resp_ready = (c < 400) ? 2'($urandom) : 2'b11;
         a0 = {1'($urandom), 8'($urandom_range(110, 144)), 23'($urandom)};
         b0 = {1'($urandom), 8'($urandom_range(110, 144)), 23'($urandom)};
         a1 = {1'($urandom), 8'($urandom_range(110, 144)), 23'($urandom)};
         b1 = {1'($urandom), 8'($urandom_range(110, 144)), 23'($urandom)};
         set_op(0, a0, b0);
         set_op(1, a1, b1);
         @(negedge clk);
         n_checks++;
         if ((req_ready & ~req_valid) != 2'b00 || req_ready == 2'b11) begin
            n_fail++;
            $display("FAIL soak_grant c%0d: got rdy=%b for valid=%b", c, req_ready, req_valid);
         end
         if (held) begin
            n_checks++;
            if ({resp_valid, resp_y} !== {held_v, held_y}) begin
               n_fail++;
               $display("FAIL soak_stable c%0d: got rv=%b y=%h want %b %h",
                        c, resp_valid, resp_y, held_v, held_y);
            end
         end
         held = 1'b0;
         if (|(resp_valid & resp_ready)) begin
            n_checks++;
            if (q_id.size() == 0) begin
               n_fail++;
               $display("FAIL soak_extra c%0d: got rv=%b with nothing outstanding", c, resp_valid);
            end else begin
               id = q_id.pop_front();
               e  = ref_mul(q_a.pop_front(), q_b.pop_front());
               d  = int'(resp_y[30:0]) - int'(e[30:0]);
               if (resp_valid !== 2'(1 << id) || resp_y[31] !== e[31] || d < -1 || d > 1) begin
                  n_fail++;
                  $display("FAIL soak_result c%0d: got rv=%b y=%h want id%0d y~%h",
                           c, resp_valid, resp_y, id, e);
               end
            end
         end else if (|resp_valid) begin
            held   = 1'b1;
            held_v = resp_valid;
            held_y = resp_y;
         end
         if (req_valid[0] && req_ready[0]) begin
            q_id.push_back(0); q_a.push_back(a0); q_b.push_back(b0);
         end
         if (req_valid[1] && req_ready[1]) begin
            q_id.push_back(1); q_a.push_back(a1); q_b.push_back(b1);
         end
         next_cycle();
      end
      n_checks++;
      if (q_id.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL soak_drain: got %0d outstanding busy=%b want 0 0", q_id.size(), busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_mixed_stall();
      test_reset_midflight();
      test_soak();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fmul_arbiter.md
Name: fmul_arbiter

Overview:
- Shares one fmul unit (combinational, ports x1, x2, y; IEEE single, normalized inputs only, 1-ulp tolerance) between N_REQ requesters, e.g. the FPU issue port and the divide/sqrt iteration engine.
- Round-robin arbitration, a LAT-cycle registered pipeline around fmul, per-requester result return with backpressure and bubble collapse.
- Sits between FPU issue logic and fmul inside the FPU.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- LAT, 2, cycles from accept to resp_valid (1..4).

Ports:
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  requester i has an operation.
- req_x1  in  32*N_REQ  operand 1; slice i = bits [32i+31:32i].
- req_x2  in  32*N_REQ  operand 2, same slicing.
- req_ready  out  N_REQ  one-hot grant; accept = req_valid[i] & req_ready[i].
- resp_valid  out  N_REQ  result available for requester i (at most one bit set).
- resp_y  out  32  product, valid when any resp_valid bit is set.
- resp_ready  in  N_REQ  requester i takes result.
- busy  out  1  any pipeline stage valid.

Behaviour:
- Reset (rstn low, asynchronous): all stage valid bits 0; RR pointer = 0; req_ready = 0; resp_valid = 0; busy = 0. Stage data registers are don't-care.
- Reset mid-operation drops all in-flight results silently; no resp_valid follows.
- Pipeline: stages s[0..LAT-1], each holding {valid, id, data}.
  - s[0].data = {x1, x2}; fmul takes s[0] operands.
  - s[1].data = fmul y, then passed unchanged through s[2..LAT-1].
  - Head = s[LAT-1]. For LAT=1, head = s[0] and resp_y = fmul(s[0]) combinationally.
- Advance rules:
  - Head: adv[LAT-1] = !s[LAT-1].valid | resp_ready[s[LAT-1].id].
  - Other stages: adv[k] = !s[k+1].valid | adv[k+1].
  - Bubble collapse: a stalled head does not stop upstream stages from filling empty slots.
  - Stage k+1 loads s[k] when adv[k] is set; s[k].valid clears when it moves on and nothing enters behind it.
- Response:
  - resp_valid[i] = s[LAT-1].valid & (s[LAT-1].id == i).
  - resp_y is stable while resp_valid is held without resp_ready.
- Arbitration:
  - Grant only when adv[0] is set.
  - Winner = first i with req_valid[i], searching circularly from the RR pointer.
  - req_ready is the one-hot winner; all bits 0 if there is no request or adv[0] is 0.
  - req_ready depends combinationally on req_valid and resp_ready; no combinational path from req_x1/req_x2.
  - On accept: s[0] <= {1, i, x1, x2} and pointer <= (i+1) mod N_REQ.
  - Without an accept the pointer holds.
- Throughput: one accept per cycle when unstalled; back-to-back results on consecutive cycles.
- Ordering: results return in acceptance order across all requesters; no reordering.
- Simultaneous head dequeue and s[0] accept in the same cycle is legal and keeps the pipeline full.
- busy = OR of stage valid bits.
- NaN/Inf/denormal handling is inherited from fmul; the arbiter passes data unchanged.

Decomposition:
- Shared package fpu_sched_pkg:
  - ID_W = $clog2(N_REQ), minimum 1.
  - typedef stage_t {logic valid; logic [ID_W-1:0] id; logic [63:0] data;}, where data holds operands in s[0] and the result in [31:0] afterwards.
  - Constant FMUL_LAT_MAX = 4.
- One sub-module, rr_arbiter (N parameter; inputs req, en; outputs one-hot gnt; internal pointer), instantiated once. The fmul instance sits directly in fmul_arbiter.

Test Plan:
- Reset, single op: assert/deassert rstn; req0 0x3FC00000 * 0x40000000, LAT=2, resp_ready all 1 -> req_ready=01 in cycle 0; resp_valid=01 with resp_y=0x40400000 exactly at cycle 2; busy 1 over cycles 1..2, 0 afterwards.
- Contention fairness: both requesters valid every cycle (req0 1.0*1.0, req1 0x40400000*0xBF000000) -> grants alternate 01,10,01,...; responses alternate 0x3F800000 / 0xBFC00000; none lost.
- Backpressure with collapse: resp_ready[0]=0 for 5 cycles while req0 streams -> head held with stable resp_y; exactly LAT ops accepted; req_ready=0 once full; on release, results drain in order, one per cycle.
- Mixed stall: head belongs to req1 with resp_ready[1]=0 while req0 requests -> req0 stalls behind it, no overtaking; order preserved after release.
- Reset mid-flight: drop rstn while 2 ops are in flight -> resp_valid=0 immediately and asynchronously; no stale result after rstn rises; RR pointer back to 0, so first grant goes to req0.
- Random soak: random valid/ready on both ports, random normalized operands -> every accepted op returns exactly once, in accept order, matching shortreal product within 1 ulp.
